// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control symbols, symbol width, disparity type and small helpers.
// Also used by the 10:5 gearbox and the planned TMDS decoder/checker.
package tmds_pkg;

   localparam int TMDS_SYMBOL_WIDTH = 10;

   localparam logic [TMDS_SYMBOL_WIDTH-1:0] TMDS_CTRL_00 = 10'h354;
   localparam logic [TMDS_SYMBOL_WIDTH-1:0] TMDS_CTRL_01 = 10'h0AB;
   localparam logic [TMDS_SYMBOL_WIDTH-1:0] TMDS_CTRL_10 = 10'h154;
   localparam logic [TMDS_SYMBOL_WIDTH-1:0] TMDS_CTRL_11 = 10'h2AB;

   // Running disparity, always even and bounded to [-10, +10].
   typedef logic signed [4:0] tmds_disparity_t;

   function automatic logic [3:0] tmdsPopcount8(input logic [7:0] value);
      logic [3:0] total;
      total = '0;
      for (int i = 0; i < 8; i++) begin
         total = total + {3'b000, value[i]};
      end
      return total;
   endfunction

   function automatic logic [TMDS_SYMBOL_WIDTH-1:0] tmdsControlSymbol(input logic [1:0] ctrl);
      logic [TMDS_SYMBOL_WIDTH-1:0] sym;
      case (ctrl)
         2'b00:   sym = TMDS_CTRL_00;
         2'b01:   sym = TMDS_CTRL_01;
         2'b10:   sym = TMDS_CTRL_10;
         default: sym = TMDS_CTRL_11;
      endcase
      return sym;
   endfunction

endpackage

// File: rtl/tmds_transition_minimiser.sv
// Combinational first half of TMDS encoding: picks XOR or XNOR chaining to
// minimise transitions and reports the ones count of the resulting 8 data bits.
module tmds_transition_minimiser
   import tmds_pkg::*;
(
   input  logic [7:0] data_i,
   output logic [8:0] qm_o,
   output logic [3:0] ones_o
);

   logic [3:0] dataOnes;
   logic       useXnor;

   always_comb begin
      dataOnes = tmdsPopcount8(data_i);
      useXnor  = (dataOnes > 4'd4) || ((dataOnes == 4'd4) && !data_i[0]);
      qm_o     = '0;
      qm_o[0]  = data_i[0];
      for (int i = 1; i < 8; i++) begin
         qm_o[i] = useXnor ? ~(qm_o[i-1] ^ data_i[i]) : (qm_o[i-1] ^ data_i[i]);
      end
      qm_o[8]  = ~useXnor;
      ones_o   = tmdsPopcount8(qm_o[7:0]);
   end

endmodule

// File: rtl/tmds_symbol_encoder.sv
// Pipelined DVI TMDS 8b/10b encoder for one colour channel: optional input
// register, transition minimisation stage, then DC-balance stage with running disparity.
module tmds_symbol_encoder
   import tmds_pkg::*;
#(
   parameter bit REGISTER_INPUTS = 1'b1
) (
   input  logic                         clkPixel,
   input  logic                         reset,
   input  logic [7:0]                   pixelData,
   input  logic                         dataEnable,
   input  logic [1:0]                   control,
   output logic [TMDS_SYMBOL_WIDTH-1:0] symbol,
   output logic                         symbolDataEnable
);

   localparam tmds_disparity_t DispZero = 5'sd0;
   localparam tmds_disparity_t DispTwo  = 5'sd2;
   localparam tmds_disparity_t DispEight = 5'sd8;

   logic [7:0] s1Data;
   logic       s1De;
   logic [1:0] s1Ctrl;

   generate
      if (REGISTER_INPUTS) begin : gInputReg
         logic [7:0] data_q;
         logic       de_q;
         logic [1:0] ctrl_q;

         always_ff @(posedge clkPixel or posedge reset) begin
            if (reset) begin
               data_q <= '0;
               de_q   <= 1'b0;
               ctrl_q <= 2'b00;
            end else begin
               data_q <= pixelData;
               de_q   <= dataEnable;
               ctrl_q <= control;
            end
         end

         assign s1Data = data_q;
         assign s1De   = de_q;
         assign s1Ctrl = ctrl_q;
      end else begin : gNoInputReg
         assign s1Data = pixelData;
         assign s1De   = dataEnable;
         assign s1Ctrl = control;
      end
   endgenerate

   logic [8:0] qm_d, qm_q;
   logic [3:0] ones_d, ones_q;
   logic       de2_q;
   logic [1:0] ctrl2_q;

   tmds_transition_minimiser uMinimiser (
      .data_i (s1Data),
      .qm_o   (qm_d),
      .ones_o (ones_d)
   );

   always_ff @(posedge clkPixel or posedge reset) begin
      if (reset) begin
         qm_q    <= '0;
         ones_q  <= '0;
         de2_q   <= 1'b0;
         ctrl2_q <= 2'b00;
      end else begin
         qm_q    <= qm_d;
         ones_q  <= ones_d;
         de2_q   <= s1De;
         ctrl2_q <= s1Ctrl;
      end
   end

   logic [TMDS_SYMBOL_WIDTH-1:0] symbol_d, symbol_q;
   logic                         de3_q;
   tmds_disparity_t              cnt_d, cnt_q;
   tmds_disparity_t              onesS, zerosS, balance;

   // balance is n1-n0 of q_m[7:0]; every branch adds exactly the disparity of the emitted symbol.
   always_comb begin
      onesS    = tmds_disparity_t'({1'b0, ones_q});
      zerosS   = DispEight - onesS;
      balance  = onesS - zerosS;
      symbol_d = tmdsControlSymbol(ctrl2_q);
      cnt_d    = DispZero;
      if (de2_q) begin
         if ((cnt_q == DispZero) || (balance == DispZero)) begin
            symbol_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d    = cnt_q + (qm_q[8] ? balance : -balance);
         end else if (((cnt_q > DispZero) && (balance > DispZero)) ||
                      ((cnt_q < DispZero) && (balance < DispZero))) begin
            symbol_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d    = cnt_q + (qm_q[8] ? DispTwo : DispZero) - balance;
         end else begin
            symbol_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d    = cnt_q - (qm_q[8] ? DispZero : DispTwo) + balance;
         end
      end
   end

   always_ff @(posedge clkPixel or posedge reset) begin
      if (reset) begin
         symbol_q <= TMDS_CTRL_00;
         de3_q    <= 1'b0;
         cnt_q    <= DispZero;
      end else begin
         symbol_q <= symbol_d;
         de3_q    <= de2_q;
         cnt_q    <= cnt_d;
      end
   end

   assign symbol           = symbol_q;
   assign symbolDataEnable = de3_q;

endmodule

// File: tb/tb_tmds_symbol_encoder.sv
// Directed bench for tmds_symbol_encoder: runs the latency-3 and latency-2 builds
// side by side on one stimulus stream with hand-computed and model-derived symbols.
module tb_tmds_symbol_encoder;

   logic       clkPixel;
   logic       reset;
   logic [7:0] pixelData;
   logic       dataEnable;
   logic [1:0] control;
   logic [9:0] symbol3, symbol2;
   logic       symbolDe3, symbolDe2;

   typedef struct {
      logic [9:0] sym;
      logic       de;
      logic [7:0] data;
      int         idx;
   } exp_t;

   exp_t q3[$];
   exp_t q2[$];
   int   checks   = 0;
   int   errors   = 0;
   int   stepNo   = 0;
   int   modelCnt = 0;
   int   runDisp  = 0;

   tmds_symbol_encoder #(.REGISTER_INPUTS(1'b1)) dut (
      .clkPixel         (clkPixel),
      .reset            (reset),
      .pixelData        (pixelData),
      .dataEnable       (dataEnable),
      .control          (control),
      .symbol           (symbol3),
      .symbolDataEnable (symbolDe3)
   );

   tmds_symbol_encoder #(.REGISTER_INPUTS(1'b0)) dutNoReg (
      .clkPixel         (clkPixel),
      .reset            (reset),
      .pixelData        (pixelData),
      .dataEnable       (dataEnable),
      .control          (control),
      .symbol           (symbol2),
      .symbolDataEnable (symbolDe2)
   );

   initial clkPixel = 1'b0;
   always #5 clkPixel = ~clkPixel;

   task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("[TB] FAIL %s: observed=0x%03h expected=0x%03h", tag, observed, expected);
         $error("[TB] check %s did not match", tag);
      end
   endtask

   // Reference encoder written straight from the DVI algorithm, tracking its own disparity.
   function automatic logic [9:0] modelEncode(input logic de, input logic [7:0] d, input logic [1:0] c);
      int         n1, n0, n1d;
      logic       xn;
      logic [8:0] qm;
      if (!de) begin
         modelCnt = 0;
         case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
         endcase
      end
      n1d   = $countones(d);
      xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm    = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~xn;
      n1    = $countones(qm[7:0]);
      n0    = 8 - n1;
      if (modelCnt == 0 || n1 == n0) begin
         if (qm[8]) begin
            modelCnt += n1 - n0;
            return {2'b01, qm[7:0]};
         end
         modelCnt += n0 - n1;
         return {2'b10, ~qm[7:0]};
      end
      if ((modelCnt > 0 && n1 > n0) || (modelCnt < 0 && n0 > n1)) begin
         modelCnt += (qm[8] ? 2 : 0) + n0 - n1;
         return {1'b1, qm[8], ~qm[7:0]};
      end
      modelCnt += n1 - n0 - (qm[8] ? 0 : 2);
      return {1'b0, qm[8], qm[7:0]};
   endfunction

   function automatic logic [7:0] decodeSym(input logic [9:0] s);
      logic [7:0] d, out;
      d      = s[9] ? ~s[7:0] : s[7:0];
      out    = '0;
      out[0] = d[0];
      for (int i = 1; i < 8; i++) out[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      return out;
   endfunction

   task automatic popCheck();
      exp_t e;
      if (q3.size() == 3) begin
         e = q3.pop_front();
         checkOutput($sformatf("sym3_step%0d", e.idx), symbol3, e.sym);
         checkOutput($sformatf("de3_step%0d", e.idx), {9'b0, symbolDe3}, {9'b0, e.de});
         if (e.de) begin
            checkOutput($sformatf("decode_step%0d", e.idx), {2'b00, decodeSym(symbol3)}, {2'b00, e.data});
            runDisp += 2 * $countones(symbol3) - 10;
            checkOutput($sformatf("disparity_step%0d", e.idx),
                        (runDisp >= -10 && runDisp <= 10) ? 10'd1 : 10'd0, 10'd1);
         end else begin
            runDisp = 0;
         end
      end
      if (q2.size() == 2) begin
         e = q2.pop_front();
         checkOutput($sformatf("sym2_step%0d", e.idx), symbol2, e.sym);
         checkOutput($sformatf("de2_step%0d", e.idx), {9'b0, symbolDe2}, {9'b0, e.de});
      end
   endtask

   task automatic applyStimulus(input logic de, input logic [7:0] pd, input logic [1:0] ctrl,
                                input logic [9:0] handSym, input bit useHand);
      exp_t       e;
      logic [9:0] m;
      @(negedge clkPixel);
      popCheck();
      dataEnable = de;
      pixelData  = pd;
      control    = ctrl;
      m          = modelEncode(de, pd, ctrl);
      e.sym      = useHand ? handSym : m;
      e.de       = de;
      e.data     = pd;
      e.idx      = stepNo++;
      q3.push_back(e);
      q2.push_back(e);
   endtask

   // Pipeline slots that were cleared by reset come out as control-00 blanking.
   task automatic releaseReset(input logic de, input logic [7:0] pd, input logic [9:0] handSym);
      exp_t       r, e;
      logic [9:0] m;
      @(negedge clkPixel);
      reset = 1'b0;
      q3.delete();
      q2.delete();
      modelCnt   = 0;
      runDisp    = 0;
      dataEnable = de;
      pixelData  = pd;
      control    = 2'b00;
      m          = modelEncode(de, pd, 2'b00);
      r.sym = 10'h354; r.de = 1'b0; r.data = 8'h00; r.idx = -1;
      e.sym = handSym; e.de = de;   e.data = pd;    e.idx = stepNo++;
      q3.push_back(r);
      q3.push_back(r);
      q3.push_back(e);
      q2.push_back(r);
      q2.push_back(e);
   endtask

   logic [9:0] zeroSeq [10];
   logic [9:0] oneSeq  [4];

   initial begin
      zeroSeq = '{10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100,
                  10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h100};
      oneSeq  = '{10'h1FF, 10'h300, 10'h300, 10'h1FF};
      reset      = 1'b1;
      dataEnable = 1'b0;
      pixelData  = 8'h00;
      control    = 2'b00;
      repeat (2) @(negedge clkPixel);
      checkOutput("reset_sym3", symbol3, 10'h354);
      checkOutput("reset_de3", {9'b0, symbolDe3}, 10'd0);
      checkOutput("reset_sym2", symbol2, 10'h354);
      checkOutput("reset_de2", {9'b0, symbolDe2}, 10'd0);
      releaseReset(1'b0, 8'h00, 10'h354);

      // Control symbols; pixelData must be ignored while blanking.
      applyStimulus(1'b0, 8'h5A, 2'b00, 10'h354, 1'b1);
      applyStimulus(1'b0, 8'hA5, 2'b01, 10'h0AB, 1'b1);
      applyStimulus(1'b0, 8'hFF, 2'b10, 10'h154, 1'b1);
      applyStimulus(1'b0, 8'h3C, 2'b11, 10'h2AB, 1'b1);
      applyStimulus(1'b0, 8'h00, 2'b00, 10'h354, 1'b1);

      // Ten zero pixels; control must be ignored while active.
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h00, 2'b11, zeroSeq[i], 1'b1);
      applyStimulus(1'b0, 8'h00, 2'b00, 10'h354, 1'b1);

      // Single 0xFF, then a one-cycle gap must clear the disparity.
      applyStimulus(1'b1, 8'hFF, 2'b01, 10'h200, 1'b1);
      applyStimulus(1'b0, 8'hC3, 2'b10, 10'h154, 1'b1);
      applyStimulus(1'b1, 8'h00, 2'b00, 10'h100, 1'b1);
      applyStimulus(1'b0, 8'h00, 2'b00, 10'h354, 1'b1);

      // 0x01 exercises both balance branches with q_m[8]=1.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h01, 2'b00, oneSeq[i], 1'b1);
      applyStimulus(1'b0, 8'h00, 2'b01, 10'h0AB, 1'b1);

      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 7) != 0), 8'($urandom), 2'($urandom), 10'h000, 1'b0);
      end

      // Asynchronous reset in the middle of active video.
      applyStimulus(1'b0, 8'h00, 2'b00, 10'h354, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h00, 2'b00, zeroSeq[i], 1'b1);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_reset_sym3", symbol3, 10'h354);
      checkOutput("async_reset_de3", {9'b0, symbolDe3}, 10'd0);
      checkOutput("async_reset_sym2", symbol2, 10'h354);
      checkOutput("async_reset_de2", {9'b0, symbolDe2}, 10'd0);
      @(posedge clkPixel);
      #1;
      checkOutput("held_reset_sym3", symbol3, 10'h354);
      releaseReset(1'b1, 8'h00, 10'h100);
      applyStimulus(1'b1, 8'h00, 2'b00, 10'h3FF, 1'b1);
      applyStimulus(1'b1, 8'h00, 2'b00, 10'h100, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 2'b10, 10'h154, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
